mem_ctrl: RTL

- Single-port memory controller between the pipeline and the 8-bit external RAM.
- Arbitrates between instruction fetch (IF, 4-byte reads) and the MEM stage (1/2/4-byte loads and stores).
- Sequences each access as consecutive byte transfers, assembles little-endian words, and returns a one-cycle done pulse to the owning requester.
- Sits below the IF and MEM stages; its busy flag feeds the stall controller.

---
 rtl/mem_ctrl_if.sv | 55 +++++
 rtl/mem_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request, response and external RAM signals of the memory controller.
// Define MEMCTRL_SEXT_EN to add the mem_sext_i load sign-extension request bit.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [31:0]       if_data_o;
  logic              if_done_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_len_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic [31:0]       mem_rdata_o;
  logic              mem_done_o;

  logic [7:0]        ram_din_i;
  logic [7:0]        ram_dout_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;

`ifdef MEMCTRL_SEXT_EN
  logic              mem_sext_i;

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i,
           mem_wdata_i, mem_sext_i, ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_dout_o, ram_a_o,
           ram_wr_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i,
           mem_wdata_i, mem_sext_i, ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_dout_o, ram_a_o,
           ram_wr_o
  );
`else
  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i,
           mem_wdata_i, ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_dout_o, ram_a_o,
           ram_wr_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i,
           mem_wdata_i, ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_dout_o, ram_a_o,
           ram_wr_o
  );
`endif
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port controller serialising IF fetches and MEM loads/stores
// onto an 8-bit RAM, assembling little-endian words and pulsing done per requester.
// MEM has fixed priority; grants run to completion; one idle cycle after each done.
// Define MEMCTRL_SEXT_EN to add mem_sext_i (sign-extend byte/half loads).
module mem_ctrl #(
  parameter int ADDR_W        = 32,
  parameter int RAM_ADDR_BITS = 17
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_ctrl_if.slave bus,
  output logic      busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_e;

  localparam logic [ADDR_W-1:0] RAM_MASK = (ADDR_W'(1) << RAM_ADDR_BITS) - ADDR_W'(1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              owner_mem_q, owner_mem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              mem_done_q, mem_done_d;
`ifdef MEMCTRL_SEXT_EN
  logic              sext_q, sext_d;
`endif

  logic [ADDR_W-1:0] step_addr;
  logic [1:0]        byte_idx;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Next-state logic: grant arbitration in IDLE, byte sequencing in READ/WRITE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    owner_mem_d = owner_mem_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_data_d   = if_data_q;
    if_done_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;
`ifdef MEMCTRL_SEXT_EN
    sext_d      = sext_q;
`endif
    step_addr   = addr_q + ADDR_W'(cnt_q);
    byte_idx    = 2'(cnt_q - 3'd2);

    case (state_q)
      IDLE: begin
        if (!if_done_q && !mem_done_q) begin
          if (bus.mem_req_i) begin
            owner_mem_d = 1'b1;
            addr_d      = bus.mem_addr_i;
            n_d         = len_to_n(bus.mem_len_i);
            wdata_d     = bus.mem_wdata_i;
`ifdef MEMCTRL_SEXT_EN
            sext_d      = bus.mem_sext_i;
`endif
            ram_a_d     = bus.mem_addr_i;
            cnt_d       = 3'd1;
            rbuf_d      = 32'h0;
            if (bus.mem_we_i) begin
              state_d    = WRITE;
              ram_dout_d = bus.mem_wdata_i[7:0];
              ram_wr_d   = 1'b1;
            end else begin
              state_d    = READ;
            end
          end else if (bus.if_req_i) begin
            owner_mem_d = 1'b0;
            addr_d      = bus.if_addr_i;
            n_d         = 3'd4;
`ifdef MEMCTRL_SEXT_EN
            sext_d      = 1'b0;
`endif
            ram_a_d     = bus.if_addr_i;
            cnt_d       = 3'd1;
            rbuf_d      = 32'h0;
            state_d     = READ;
          end
        end
      end

      READ: begin
        if (cnt_q >= 3'd2) begin
          rbuf_d[{byte_idx, 3'b000} +: 8] = bus.ram_din_i;
        end
        if (cnt_q < n_q) begin
          ram_a_d = step_addr;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == n_q + 3'd1) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          if (owner_mem_q) begin
            mem_rdata_d = rbuf_d;
`ifdef MEMCTRL_SEXT_EN
            if (sext_q && n_q == 3'd1) begin
              mem_rdata_d = {{24{rbuf_d[7]}}, rbuf_d[7:0]};
            end else if (sext_q && n_q == 3'd2) begin
              mem_rdata_d = {{16{rbuf_d[15]}}, rbuf_d[15:0]};
            end
`endif
            mem_done_d  = 1'b1;
          end else begin
            if_data_d = rbuf_d;
            if_done_d = 1'b1;
          end
        end
      end

      WRITE: begin
        if (cnt_q == n_q) begin
          state_d    = IDLE;
          cnt_d      = 3'd0;
          mem_done_d = 1'b1;
        end else begin
          ram_a_d    = step_addr;
          ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers: synchronous reset, frozen entirely while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      owner_mem_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rbuf_q      <= 32'h0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'h0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= 32'h0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= 32'h0;
      mem_done_q  <= 1'b0;
`ifdef MEMCTRL_SEXT_EN
      sext_q      <= 1'b0;
`endif
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      owner_mem_q <= owner_mem_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_data_q   <= if_data_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
`ifdef MEMCTRL_SEXT_EN
      sext_q      <= sext_d;
`endif
    end
  end

  assign bus.if_data_o   = if_data_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.mem_done_o  = mem_done_q;
  assign bus.ram_dout_o  = ram_dout_q;
  assign bus.ram_a_o     = ram_a_q & RAM_MASK;
  assign bus.ram_wr_o    = ram_wr_q & rdy;
  assign busy_o          = (state_q != IDLE);

endmodule
